// File: rtl/tag_sched_ctrl.sv
// Scheduler between the instruction decoder and the double-buffer tag allocator.
// Issues tag requests, tracks pending compute/store phases, flushes and reports completion.
module tag_sched_ctrl #(
    parameter int NUM_TAGS  = 2,
    parameter int TAG_W     = $clog2(NUM_TAGS),
    parameter int BLK_CNT_W = 16,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [BLK_CNT_W-1:0] num_blocks,
    input  logic                 instr_valid,
    input  logic                 instr_reuse,
    output logic                 instr_ready,
    output logic                 tag_req,
    output logic                 tag_reuse,
    input  logic                 tag_ready,
    input  logic [TAG_W-1:0]     tag,
    input  logic                 compute_tag_done,
    input  logic                 stmem_tag_done,
    output logic                 block_done,
    output logic [TAG_W-1:0]     last_tag,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_CMP,
        FLUSH,
        DRAIN,
        FIN
    } state_t;

    state_t               state;
    logic [BLK_CNT_W-1:0] blk_left;
    logic [CNT_W-1:0]     cmp_pend;
    logic [CNT_W-1:0]     st_pend;
    logic                 first_flag;

    logic                 reuse_eff;
    logic                 gate;
    logic                 accept;
    logic [CNT_W-1:0]     cmp_nxt;
    logic [CNT_W-1:0]     st_nxt;
    logic                 cmp_err;
    logic                 st_err;

    // Saturating up/down step: returns {error, next}; the counter holds on error.
    function automatic logic [CNT_W:0] cnt_step(
        input logic [CNT_W-1:0] c,
        input logic             inc,
        input logic             dec
    );
        logic [CNT_W:0] r;
        r = {1'b0, c};
        case ({inc, dec})
            2'b10: r = (&c) ? {1'b1, c} : {1'b0, c + CNT_W'(1)};
            2'b01: r = (c == '0) ? {1'b1, c} : {1'b0, c - CNT_W'(1)};
            default: r = {1'b0, c};
        endcase
        return r;
    endfunction

    always_comb begin
        reuse_eff   = instr_reuse & ~first_flag;
        gate        = tag_ready & (reuse_eff | (st_pend < CNT_W'(NUM_TAGS)));
        accept      = (state == ISSUE) & instr_valid & gate;
        tag_req     = accept;
        instr_ready = accept;
        tag_reuse   = accept & reuse_eff;
        {cmp_err, cmp_nxt} = cnt_step(cmp_pend, accept, compute_tag_done);
        {st_err, st_nxt}   = cnt_step(st_pend, accept & ~reuse_eff, stmem_tag_done);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            blk_left   <= '0;
            cmp_pend   <= '0;
            st_pend    <= '0;
            first_flag <= 1'b0;
            last_tag   <= '0;
            block_done <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            block_done <= 1'b0;
            done       <= 1'b0;
            if (state != IDLE) begin
                cmp_pend <= cmp_nxt;
                st_pend  <= st_nxt;
                if (cmp_err | st_err)
                    err <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        blk_left   <= num_blocks;
                        err        <= 1'b0;
                        first_flag <= 1'b1;
                        cmp_pend   <= '0;
                        st_pend    <= '0;
                        busy       <= 1'b1;
                        if (num_blocks != '0) begin
                            state <= ISSUE;
                        end else begin
                            state <= FIN;
                            done  <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (accept) begin
                        last_tag   <= tag;
                        blk_left   <= blk_left - BLK_CNT_W'(1);
                        first_flag <= 1'b0;
                        if (blk_left == BLK_CNT_W'(1))
                            state <= WAIT_CMP;
                    end
                end
                WAIT_CMP: begin
                    if (cmp_pend == '0) begin
                        state      <= FLUSH;
                        block_done <= 1'b1;
                    end
                end
                FLUSH: begin
                    state <= DRAIN;
                end
                DRAIN: begin
                    if (st_pend == '0) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end
                end
                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tag_sched_ctrl.sv
// Randomized and directed bench for tag_sched_ctrl against a behavioural model
// with an emulated allocator producing compute/store done pulses.
module tb_tag_sched_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] num_blocks;
    logic        instr_valid;
    logic        instr_reuse;
    logic        instr_ready;
    logic        tag_req;
    logic        tag_reuse;
    logic        tag_ready;
    logic [0:0]  tag;
    logic        compute_tag_done;
    logic        stmem_tag_done;
    logic        block_done;
    logic [0:0]  last_tag;
    logic        busy;
    logic        done;
    logic        err;

    tag_sched_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .num_blocks(num_blocks),
        .instr_valid(instr_valid), .instr_reuse(instr_reuse),
        .instr_ready(instr_ready), .tag_req(tag_req), .tag_reuse(tag_reuse),
        .tag_ready(tag_ready), .tag(tag),
        .compute_tag_done(compute_tag_done), .stmem_tag_done(stmem_tag_done),
        .block_done(block_done), .last_tag(last_tag), .busy(busy),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    localparam int M_OFF = 0, M_REQ = 1, M_CMP = 2, M_FLUSH = 3, M_STORE = 4, M_END = 5;

    int checks = 0;
    int errors = 0;

    int m_ph, m_left, m_cp, m_sp, m_first, m_err, m_last, m_acc;
    int cyc = 0;
    int cq[$];
    int cq_r[$];
    int sq[$];
    int cdly, sdly;
    int reuse_mode;
    int reuse_pat[$];
    int obs_reuse[$];
    bit rnd_valid, rnd_ready, inj_cmp_err;
    int n_acc, n_bd, n_done, n_busy;

    task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", nm, obs, exp, $time);
        end
    endtask

    task automatic pend(inout int c, input bit inc, input bit dec);
        if (inc && !dec) begin
            if (c == 255) m_err = 1;
            else c = c + 1;
        end else if (dec && !inc) begin
            if (c == 0) m_err = 1;
            else c = c - 1;
        end
    endtask

    task automatic model_reset();
        m_ph = M_OFF; m_left = 0; m_cp = 0; m_sp = 0;
        m_first = 0; m_err = 0; m_last = 0;
    endtask

    task automatic set_inputs();
        start = 1'b0;
        compute_tag_done = 1'b0;
        stmem_tag_done = 1'b0;
        if (cq.size() > 0 && cq[0] <= cyc) begin
            void'(cq.pop_front());
            if (cq_r.pop_front() == 0) sq.push_back(cyc + sdly);
            compute_tag_done = 1'b1;
        end
        if (inj_cmp_err && m_ph == M_CMP && m_cp == 0) begin
            compute_tag_done = 1'b1;
            inj_cmp_err = 1'b0;
        end
        if (sq.size() > 0 && sq[0] <= cyc) begin
            void'(sq.pop_front());
            stmem_tag_done = 1'b1;
        end
        instr_valid = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
        tag_ready = rnd_ready ? 1'($urandom_range(0, 3) != 0) : 1'b1;
        tag = 1'($urandom);
        case (reuse_mode)
            1: instr_reuse = 1'($urandom_range(0, 1));
            2: instr_reuse = (m_acc < reuse_pat.size()) ? 1'(reuse_pat[m_acc]) : 1'b0;
            default: instr_reuse = 1'b0;
        endcase
    endtask

    task automatic tick();
        bit re, eq;
        int ocp, osp;
        @(negedge clk);
        re = instr_reuse && (m_first == 0);
        eq = (m_ph == M_REQ) && instr_valid && tag_ready && (re || m_sp < 2);
        chk("tag_req", 32'(tag_req), 32'(eq));
        chk("instr_ready", 32'(instr_ready), 32'(eq));
        chk("tag_reuse", 32'(tag_reuse), 32'(eq && re));
        chk("busy", 32'(busy), 32'(m_ph != M_OFF));
        chk("block_done", 32'(block_done), 32'(m_ph == M_FLUSH));
        chk("done", 32'(done), 32'(m_ph == M_END));
        chk("err", 32'(err), 32'(m_err));
        chk("last_tag", 32'(last_tag), 32'(m_last));
        n_acc += int'(tag_req === 1'b1);
        n_bd += int'(block_done === 1'b1);
        n_done += int'(done === 1'b1);
        n_busy += int'(busy === 1'b1);
        if (tag_req === 1'b1) obs_reuse.push_back(int'(tag_reuse));
        if (m_ph == M_OFF) begin
            if (start) begin
                m_err = 0; m_first = 1; m_cp = 0; m_sp = 0;
                m_left = int'(num_blocks);
                m_ph = (m_left == 0) ? M_END : M_REQ;
            end
        end else begin
            ocp = m_cp;
            osp = m_sp;
            pend(m_cp, eq, compute_tag_done);
            pend(m_sp, eq && !re, stmem_tag_done);
            if (eq) begin
                cq.push_back(cyc + cdly);
                cq_r.push_back(int'(re));
                m_acc++;
            end
            case (m_ph)
                M_REQ:
                    if (eq) begin
                        m_last = int'(tag);
                        m_left--;
                        m_first = 0;
                        if (m_left == 0) m_ph = M_CMP;
                    end
                M_CMP: if (ocp == 0) m_ph = M_FLUSH;
                M_FLUSH: m_ph = M_STORE;
                M_STORE: if (osp == 0) m_ph = M_END;
                default: m_ph = M_OFF;
            endcase
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n, input bit spur);
        for (int k = 0; k < n; k++) begin
            set_inputs();
            if (spur) begin
                compute_tag_done = 1'($urandom_range(0, 1));
                stmem_tag_done = 1'($urandom_range(0, 1));
            end
            tick();
        end
    endtask

    task automatic do_run(input int nb, input int cd, input int sd, input int abort_at);
        bit fin = 0;
        cdly = cd; sdly = sd;
        cq.delete(); cq_r.delete(); sq.delete(); obs_reuse.delete();
        m_acc = 0; n_acc = 0; n_bd = 0; n_done = 0; n_busy = 0;
        set_inputs();
        start = 1'b1;
        num_blocks = 16'(nb);
        tick();
        for (int k = 0; k < 3000 && !fin; k++) begin
            if (m_ph == M_OFF) begin
                fin = 1;
            end else if (abort_at > 0 && m_acc == abort_at) begin
                start = 1'b0; instr_valid = 1'b0;
                compute_tag_done = 1'b0; stmem_tag_done = 1'b0;
                reset = 1'b1;
                #1;
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_tag_req", 32'(tag_req), 32'd0);
                chk("rst_block_done", 32'(block_done), 32'd0);
                chk("rst_done", 32'(done), 32'd0);
                chk("rst_err", 32'(err), 32'd0);
                chk("rst_last_tag", 32'(last_tag), 32'd0);
                #1;
                reset = 1'b0;
                model_reset();
                cq.delete(); cq_r.delete(); sq.delete();
                return;
            end else begin
                set_inputs();
                tick();
            end
        end
        if (!fin) begin
            checks++;
            errors++;
            $error("FAIL run_timeout observed=busy expected=idle nb=%0d", nb);
            return;
        end
        chk("n_accepts", 32'(n_acc), 32'(nb));
        chk("n_block_done", 32'(n_bd), 32'(nb != 0));
        chk("n_done", 32'(n_done), 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0; num_blocks = '0; instr_valid = 1'b0; instr_reuse = 1'b0;
        tag_ready = 1'b0; tag = '0; compute_tag_done = 1'b0; stmem_tag_done = 1'b0;
        rnd_valid = 0; rnd_ready = 0; inj_cmp_err = 0; reuse_mode = 0;
        cdly = 3; sdly = 2;
        model_reset();
        #2;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_tag_req", 32'(tag_req), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(2, 1'b0);

        // four fresh blocks, compute 3 after accept, store 2 after compute
        do_run(4, 3, 2, 0);
        idle(2, 1'b0);

        // slow compute forces st_pend to NUM_TAGS and stalls the third block
        do_run(4, 6, 4, 0);
        idle(2, 1'b0);

        reuse_mode = 2;
        reuse_pat = '{1, 1, 0};
        do_run(3, 5, 2, 0);
        chk("reuse_cnt", 32'(obs_reuse.size()), 32'd3);
        if (obs_reuse.size() == 3) begin
            chk("reuse0", 32'(obs_reuse[0]), 32'd0);
            chk("reuse1", 32'(obs_reuse[1]), 32'd1);
            chk("reuse2", 32'(obs_reuse[2]), 32'd0);
        end
        reuse_mode = 0;
        idle(2, 1'b0);

        do_run(0, 3, 2, 0);
        chk("zero_busy_cycles", 32'(n_busy), 32'd1);
        idle(3, 1'b1);

        inj_cmp_err = 1;
        do_run(2, 3, 2, 0);
        chk("err_sticky", 32'(err), 32'd1);
        idle(4, 1'b1);
        chk("err_held_idle", 32'(err), 32'd1);
        do_run(1, 2, 2, 0);
        chk("err_cleared", 32'(err), 32'd0);
        idle(2, 1'b0);

        do_run(5, 4, 2, 2);
        idle(3, 1'b0);
        do_run(1, 3, 2, 0);
        idle(2, 1'b0);

        reuse_mode = 1; rnd_valid = 1; rnd_ready = 1;
        for (int r = 0; r < 25; r++) begin
            inj_cmp_err = ($urandom_range(0, 4) == 0);
            do_run($urandom_range(1, 8), $urandom_range(1, 6), $urandom_range(1, 5), 0);
            inj_cmp_err = 0;
            idle($urandom_range(1, 4), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
